lcd_disp_ctrl: RTL and testbench



---
 rtl/lcd_disp_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lcd_disp_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_disp_ctrl.sv
// rtl/lcd_disp_ctrl.sv - frame-synchronous display-state controller for the LCD datapath
// Optional feature macro: DISP_MSG_TIMEOUT_EN (auto-clear of money_flag after MSG_FRAMES frames)
module lcd_disp_ctrl #(
   parameter int GOODS_NUM    = 10,
   parameter int MONEY_MAX    = 99,
   parameter int MSG_FRAMES   = 120,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        lcd_pclk,
   input  logic        rstn,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [3:0]  upd_goods,
   input  logic [6:0]  upd_money,
   input  logic [1:0]  upd_msg,
   output logic [3:0]  goods_index,
   output logic [6:0]  money,
   output logic [1:0]  money_flag,
   output logic        point_flag
);

   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   // Both frame counts must be at least one frame long
   if (MSG_FRAMES < 1) begin : g_bad_msg_frames
      $error("MSG_FRAMES must be at least 1");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
      $error("BLINK_FRAMES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state;
   state_t               state_n;
   logic                 org;
   logic                 org_d;
   logic                 tick;
   logic                 xfer;
   logic                 commit;
   logic [3:0]           sh_goods;
   logic [6:0]           sh_money;
   logic [1:0]           sh_msg;
   logic [BLINK_W-1:0]   blink_cnt;

`ifdef DISP_MSG_TIMEOUT_EN
   localparam int MSG_W = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;
   localparam logic [MSG_W-1:0] MSG_LAST = MSG_W'(MSG_FRAMES - 1);

   logic [MSG_W-1:0]     msg_cnt;
   logic                 msg_cnt_clr;
   logic                 msg_cnt_inc;
   logic                 msg_clr;
`endif

   // Frame origin seen this cycle; only its rising edge is a frame tick
   assign org  = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
   assign tick = org & ~org_d;
   assign xfer = upd_valid & upd_ready;

   // Delayed origin flag so a lingering (0,0) gives a single tick
   always_ff @(posedge lcd_pclk or negedge rstn) begin
      if (!rstn) org_d <= 1'b0;
      else       org_d <= org;
   end

   // State register and registered ready (low only while an update is pending)
   always_ff @(posedge lcd_pclk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         upd_ready <= 1'b1;
      end else begin
         state     <= state_n;
         upd_ready <= (state_n != PEND);
      end
   end

   // Next-state and commit/timeout strobes; a transfer always beats a tick
   always_comb begin
      state_n = state;
      commit  = 1'b0;
`ifdef DISP_MSG_TIMEOUT_EN
      msg_cnt_clr = 1'b0;
      msg_cnt_inc = 1'b0;
      msg_clr     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (xfer) state_n = PEND;
         end
         PEND: begin
            if (tick) begin
               commit = 1'b1;
`ifdef DISP_MSG_TIMEOUT_EN
               if (sh_msg != 2'd0) begin
                  state_n     = HOLD;
                  msg_cnt_clr = 1'b1;
               end else begin
                  state_n = IDLE;
               end
`else
               state_n = IDLE;
`endif
            end
         end
`ifdef DISP_MSG_TIMEOUT_EN
         HOLD: begin
            if (xfer) begin
               state_n = PEND;
            end else if (tick) begin
               if (msg_cnt == MSG_LAST) begin
                  msg_clr = 1'b1;
                  state_n = IDLE;
               end else begin
                  msg_cnt_inc = 1'b1;
               end
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // Shadow capture with goods index and money clamped to displayable range
   always_ff @(posedge lcd_pclk or negedge rstn) begin
      if (!rstn) begin
         sh_goods <= '0;
         sh_money <= '0;
         sh_msg   <= '0;
      end else if (xfer) begin
         sh_goods <= ({1'b0, upd_goods} >= 5'(GOODS_NUM)) ? 4'd0 : upd_goods;
         sh_money <= (upd_money > 7'(MONEY_MAX)) ? 7'(MONEY_MAX) : upd_money;
         sh_msg   <= upd_msg;
      end
   end

`ifdef DISP_MSG_TIMEOUT_EN
   // Frames spent holding a message; stops at its terminal value
   always_ff @(posedge lcd_pclk or negedge rstn) begin
      if (!rstn)            msg_cnt <= '0;
      else if (msg_cnt_clr) msg_cnt <= '0;
      else if (msg_cnt_inc) msg_cnt <= msg_cnt + 1'b1;
   end
`endif

   // Display-facing registers: every change lands on a frame tick edge
   always_ff @(posedge lcd_pclk or negedge rstn) begin
      if (!rstn) begin
         goods_index <= '0;
         money       <= '0;
         money_flag  <= '0;
         point_flag  <= 1'b0;
         blink_cnt   <= '0;
      end else if (commit) begin
         goods_index <= sh_goods;
         money       <= sh_money;
         money_flag  <= sh_msg;
         point_flag  <= (sh_goods != 4'd0);
         blink_cnt   <= '0;
      end else if (tick) begin
`ifdef DISP_MSG_TIMEOUT_EN
         if (msg_clr) money_flag <= '0;
`endif
         if (goods_index == 4'd0) begin
            point_flag <= 1'b0;
            blink_cnt  <= '0;
         end else if (blink_cnt == BLINK_LAST) begin
            point_flag <= ~point_flag;
            blink_cnt  <= '0;
         end else begin
            blink_cnt  <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_disp_ctrl.sv
// tb/tb_lcd_disp_ctrl.sv - directed self-checking bench for lcd_disp_ctrl on an 8x4 raster
module tb_lcd_disp_ctrl;

   logic        lcd_pclk;
   logic        rstn;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic        upd_valid;
   logic        upd_ready;
   logic [3:0]  upd_goods;
   logic [6:0]  upd_money;
   logic [1:0]  upd_msg;
   logic [3:0]  goods_index;
   logic [6:0]  money;
   logic [1:0]  money_flag;
   logic        point_flag;

   int checks   = 0;
   int failures = 0;

`ifdef DISP_MSG_TIMEOUT_EN
   localparam logic [1:0] FLAG_AFTER_TO = 2'd0;
`else
   localparam logic [1:0] FLAG_AFTER_TO = 2'd2;
`endif

   lcd_disp_ctrl #(
      .GOODS_NUM    (10),
      .MONEY_MAX    (99),
      .MSG_FRAMES   (3),
      .BLINK_FRAMES (2)
   ) dut (
      .lcd_pclk    (lcd_pclk),
      .rstn        (rstn),
      .pixel_xpos  (pixel_xpos),
      .pixel_ypos  (pixel_ypos),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_goods   (upd_goods),
      .upd_money   (upd_money),
      .upd_msg     (upd_msg),
      .goods_index (goods_index),
      .money       (money),
      .money_flag  (money_flag),
      .point_flag  (point_flag)
   );

   initial lcd_pclk = 1'b0;
   always #5 lcd_pclk = ~lcd_pclk;

   // 8x4 raster, one pixel per clock, updated just after each rising edge
   initial begin
      pixel_xpos = '0;
      pixel_ypos = '0;
      forever begin
         @(posedge lcd_pclk);
         #1;
         if (pixel_xpos == 11'd7) begin
            pixel_xpos = '0;
            pixel_ypos = (pixel_ypos == 11'd3) ? 11'd0 : pixel_ypos + 11'd1;
         end else begin
            pixel_xpos = pixel_xpos + 11'd1;
         end
      end
   end

   // Advance to the falling edge at which the raster presents (x,y)
   task automatic wait_pos(input int x, input int y);
      bit found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge lcd_pclk);
         if (pixel_xpos == 11'(x) && pixel_ypos == 11'(y)) found = 1'b1;
      end
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL wait_pos raster=(%0d,%0d) required=(%0d,%0d)", pixel_xpos, pixel_ypos, x, y);
      end
   endtask

   // Step to the falling edge just after the next frame tick edge
   task automatic next_tick();
      wait_pos(0, 0);
      @(negedge lcd_pclk);
   endtask

   // One-cycle transfer launched at raster (4,2), far from the frame origin
   task automatic do_xfer(input logic [3:0] g, input logic [6:0] m, input logic [1:0] f);
      wait_pos(4, 2);
      checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL xfer_ready_before got=%b exp=1", upd_ready); end
      upd_valid = 1'b1; upd_goods = g; upd_money = m; upd_msg = f;
      @(negedge lcd_pclk);
      upd_valid = 1'b0;
      checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL xfer_ready_drop got=%b exp=0", upd_ready); end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      upd_valid = 1'b0; upd_goods = '0; upd_money = '0; upd_msg = '0;
      repeat (20) @(negedge lcd_pclk);
      checks++; if (goods_index !== 4'd0) begin failures++; $display("FAIL reset_goods got=%0d exp=0", goods_index); end
      checks++; if (money !== 7'd0)       begin failures++; $display("FAIL reset_money got=%0d exp=0", money); end
      checks++; if (money_flag !== 2'd0)  begin failures++; $display("FAIL reset_flag got=%0d exp=0", money_flag); end
      checks++; if (point_flag !== 1'b0)  begin failures++; $display("FAIL reset_point got=%b exp=0", point_flag); end
      checks++; if (upd_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", upd_ready); end
      rstn = 1'b1;
      next_tick();
      checks++; if (goods_index !== 4'd0 || money !== 7'd0 || money_flag !== 2'd0 || point_flag !== 1'b0) begin
         failures++; $display("FAIL reset_idle_tick got=%0d/%0d/%0d/%b exp=0/0/0/0", goods_index, money, money_flag, point_flag);
      end
   endtask

   task automatic test_commit();
      do_xfer(4'd3, 7'd25, 2'd0);
      wait_pos(0, 0);
      checks++; if (goods_index !== 4'd0 || money !== 7'd0) begin failures++; $display("FAIL commit_early got=%0d/%0d exp=0/0", goods_index, money); end
      @(negedge lcd_pclk);
      checks++; if (goods_index !== 4'd3) begin failures++; $display("FAIL commit_goods got=%0d exp=3", goods_index); end
      checks++; if (money !== 7'd25)      begin failures++; $display("FAIL commit_money got=%0d exp=25", money); end
      checks++; if (money_flag !== 2'd0)  begin failures++; $display("FAIL commit_flag got=%0d exp=0", money_flag); end
      checks++; if (point_flag !== 1'b1)  begin failures++; $display("FAIL commit_point got=%b exp=1", point_flag); end
      checks++; if (upd_ready !== 1'b1)   begin failures++; $display("FAIL commit_ready got=%b exp=1", upd_ready); end
   endtask

   task automatic test_clamp();
      do_xfer(4'd12, 7'd120, 2'd0);
      next_tick();
      checks++; if (goods_index !== 4'd0) begin failures++; $display("FAIL clamp_goods got=%0d exp=0", goods_index); end
      checks++; if (money !== 7'd99)      begin failures++; $display("FAIL clamp_money got=%0d exp=99", money); end
      checks++; if (point_flag !== 1'b0)  begin failures++; $display("FAIL clamp_point got=%b exp=0", point_flag); end
   endtask

   task automatic test_timeout();
      logic [1:0] exp_flag [3];
      exp_flag[0] = 2'd2; exp_flag[1] = 2'd2; exp_flag[2] = FLAG_AFTER_TO;
      do_xfer(4'd0, 7'd10, 2'd2);
      next_tick();
      checks++; if (money_flag !== 2'd2) begin failures++; $display("FAIL timeout_commit got=%0d exp=2", money_flag); end
      for (int i = 0; i < 3; i++) begin
         next_tick();
         checks++; if (money_flag !== exp_flag[i]) begin failures++; $display("FAIL timeout_tick%0d got=%0d exp=%0d", i + 1, money_flag, exp_flag[i]); end
         checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready%0d got=%b exp=1", i + 1, upd_ready); end
      end
   endtask

   task automatic test_collision();
      do_xfer(4'd0, 7'd5, 2'd2);
      next_tick();
      next_tick();
      next_tick();
      wait_pos(0, 0);
      checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL coll_ready_hold got=%b exp=1", upd_ready); end
      upd_valid = 1'b1; upd_goods = 4'd0; upd_money = 7'd7; upd_msg = 2'd0;
      @(negedge lcd_pclk);
      upd_valid = 1'b0;
      checks++; if (money_flag !== 2'd2) begin failures++; $display("FAIL coll_flag_kept got=%0d exp=2", money_flag); end
      checks++; if (money !== 7'd5)      begin failures++; $display("FAIL coll_money_kept got=%0d exp=5", money); end
      checks++; if (upd_ready !== 1'b0)  begin failures++; $display("FAIL coll_ready_pend got=%b exp=0", upd_ready); end
      next_tick();
      checks++; if (money_flag !== 2'd0) begin failures++; $display("FAIL coll_flag_commit got=%0d exp=0", money_flag); end
      checks++; if (money !== 7'd7)      begin failures++; $display("FAIL coll_money_commit got=%0d exp=7", money); end
      checks++; if (upd_ready !== 1'b1)  begin failures++; $display("FAIL coll_ready_idle got=%b exp=1", upd_ready); end
   endtask

   task automatic test_blink();
      logic exp_pf [4];
      exp_pf[0] = 1'b1; exp_pf[1] = 1'b0; exp_pf[2] = 1'b0; exp_pf[3] = 1'b1;
      do_xfer(4'd5, 7'd40, 2'd0);
      next_tick();
      checks++; if (point_flag !== 1'b1) begin failures++; $display("FAIL blink_commit got=%b exp=1", point_flag); end
      for (int i = 0; i < 4; i++) begin
         next_tick();
         checks++; if (point_flag !== exp_pf[i]) begin failures++; $display("FAIL blink_tick%0d got=%b exp=%b", i + 1, point_flag, exp_pf[i]); end
      end
      do_xfer(4'd0, 7'd40, 2'd0);
      for (int i = 0; i < 4; i++) begin
         next_tick();
         checks++; if (point_flag !== 1'b0) begin failures++; $display("FAIL blink_off%0d got=%b exp=0", i, point_flag); end
      end
   endtask

   task automatic test_reset_mid_pend();
      do_xfer(4'd7, 7'd50, 2'd1);
      @(negedge lcd_pclk);
      rstn = 1'b0;
      #1;
      checks++; if (money !== 7'd0)     begin failures++; $display("FAIL rstpend_money got=%0d exp=0", money); end
      checks++; if (upd_ready !== 1'b1) begin failures++; $display("FAIL rstpend_ready got=%b exp=1", upd_ready); end
      @(negedge lcd_pclk);
      rstn = 1'b1;
      next_tick();
      checks++; if (goods_index !== 4'd0 || money !== 7'd0 || money_flag !== 2'd0) begin
         failures++; $display("FAIL rstpend_discard got=%0d/%0d/%0d exp=0/0/0", goods_index, money, money_flag);
      end
   endtask

   task automatic test_back_to_back();
      wait_pos(0, 0);
      upd_valid = 1'b1; upd_goods = 4'd2; upd_money = 7'd11; upd_msg = 2'd0;
      @(negedge lcd_pclk);
      upd_valid = 1'b0;
      checks++; if (goods_index !== 4'd0 || money !== 7'd0) begin failures++; $display("FAIL b2b_not_same_tick got=%0d/%0d exp=0/0", goods_index, money); end
      checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready got=%b exp=0", upd_ready); end
      next_tick();
      checks++; if (goods_index !== 4'd2 || money !== 7'd11) begin failures++; $display("FAIL b2b_commit got=%0d/%0d exp=2/11", goods_index, money); end
      do_xfer(4'd9, 7'd99, 2'd3);
      next_tick();
      checks++; if (goods_index !== 4'd9 || money !== 7'd99 || money_flag !== 2'd3) begin
         failures++; $display("FAIL b2b_second got=%0d/%0d/%0d exp=9/99/3", goods_index, money, money_flag);
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_clamp();
      test_timeout();
      test_collision();
      test_blink();
      test_reset_mid_pend();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
